// File: rtl/obi_memory_rr_arbiter_if.sv
// OBI address/response bundle for N parallel ports sharing one response bus.
// The arbiter uses an N-port instance upstream and a 1-port instance downstream.
interface obi_memory_rr_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
) ();
   localparam int BW = DW / 8;

   logic [N-1:0]         req;
   logic [N-1:0]         gnt;
   logic [N-1:0][AW-1:0] addr;
   logic [N-1:0]         we;
   logic [N-1:0][BW-1:0] be;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0]         rvalid;
   logic [DW-1:0]        rdata;
   logic                 err;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_memory_rr_arbiter.sv
// Round-robin OBI arbiter: NUM_MSTR masters onto one memory slave port,
// with request locking and in-order response routing via an ID FIFO.
module obi_memory_rr_arbiter #(
  parameter int NUM_MSTR        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  obi_memory_rr_arbiter_if.slave             m,
  obi_memory_rr_arbiter_if.master            s,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               proto_err
);
   localparam int IW = $clog2(NUM_MSTR);
   localparam int PW = $clog2(MAX_OUTSTANDING);

   logic [IW-1:0] prio_q, lock_idx_q, rr_sel, sel;
   logic          lock_q, found;
   logic [MAX_OUTSTANDING-1:0][IW-1:0] fifo_q;
   logic [PW-1:0] wptr_q, rptr_q;
   logic          full, empty, accept, pop;
   int            idx;

   assign full  = (outstanding == (PW+1)'(MAX_OUTSTANDING));
   assign empty = (outstanding == '0);

   always_comb begin
      rr_sel = prio_q;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_MSTR; k++) begin
         idx = int'(prio_q) + k;
         if (idx >= NUM_MSTR) idx = idx - NUM_MSTR;
         if (!found && m.req[idx]) begin
            rr_sel = IW'(idx);
            found  = 1'b1;
         end
      end
   end

   // A waiting master keeps the port until granted, regardless of priority.
   assign sel = lock_q ? lock_idx_q : rr_sel;

   assign s.req[0]   = ~reset & m.req[sel] & ~full;
   assign s.addr[0]  = m.addr[sel];
   assign s.we[0]    = m.we[sel];
   assign s.be[0]    = m.be[sel];
   assign s.wdata[0] = m.wdata[sel];

   assign accept = s.req[0] & s.gnt[0];
   assign pop    = ~reset & s.rvalid[0] & ~empty;

   assign m.gnt    = accept ? (NUM_MSTR'(1) << sel) : '0;
   assign m.rvalid = pop ? (NUM_MSTR'(1) << fifo_q[rptr_q]) : '0;
   assign m.rdata  = s.rdata;
   assign m.err    = s.err;

   always_ff @(posedge clk) begin
      if (accept) fifo_q[wptr_q] <= sel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q      <= '0;
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         outstanding <= '0;
         proto_err   <= 1'b0;
      end else begin
         if (accept) begin
            wptr_q <= wptr_q + PW'(1);
            prio_q <= (sel == IW'(NUM_MSTR-1)) ? '0 : sel + IW'(1);
            lock_q <= 1'b0;
         end else if (s.req[0]) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
         if (s.rvalid[0] && empty) proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_obi_memory_rr_arbiter.sv
// Directed bench for obi_memory_rr_arbiter; a negedge monitor scores grants
// and responses against queues filled by the stimulus process.
module tb_obi_memory_rr_arbiter;
   localparam int N = 2, AW = 32, DW = 32, MO = 4;

   logic clk = 1'b0;
   logic reset;
   logic [$clog2(MO):0] outstanding;
   logic proto_err;

   always #5 clk = ~clk;

   obi_memory_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) up ();
   obi_memory_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW)) dn ();

   obi_memory_rr_arbiter #(.NUM_MSTR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .reset(reset), .m(up), .s(dn),
      .outstanding(outstanding), .proto_err(proto_err));

   typedef struct { int idx; logic [31:0] val; } exp_t;
   exp_t gq[$];
   exp_t rq[$];
   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic push_g(input int i, input logic [31:0] a);
      exp_t e; e.idx = i; e.val = a; gq.push_back(e);
   endtask

   task automatic push_r(input int i, input logic [31:0] d);
      exp_t e; e.idx = i; e.val = d; rq.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (|up.gnt) begin
         if (gq.size() == 0) check("unexpected_gnt", 64'(up.gnt), 64'd0);
         else begin
            e = gq.pop_front();
            check("gnt_idx", 64'(up.gnt), 64'(1) << e.idx);
            check("gnt_addr", 64'(dn.addr[0]), 64'(e.val));
         end
      end
      if (|up.rvalid) begin
         if (rq.size() == 0) check("unexpected_rvalid", 64'(up.rvalid), 64'd0);
         else begin
            e = rq.pop_front();
            check("rvalid_idx", 64'(up.rvalid), 64'(1) << e.idx);
            check("rdata", 64'(up.rdata), 64'(e.val));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      up.req = '0; up.addr = '0; up.we = '0; up.be = '1; up.wdata = '0;
      dn.gnt = '0; dn.rvalid = '0; dn.rdata = '0; dn.err = 1'b0;

      // reset: outputs quiet even with a request pending
      cyc(); up.req = 2'b01; dn.gnt = 1'b1;
      @(negedge clk);
      check("rst_sreq", 64'(dn.req), 64'd0);
      check("rst_gnt", 64'(up.gnt), 64'd0);
      cyc(); up.req = '0; reset = 1'b0;
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_proto_err", 64'(proto_err), 64'd0);

      // single master, back-to-back reads with 1-cycle responses
      up.req = 2'b01; up.addr[0] = 32'h100; push_g(0, 32'h100); cyc();
      up.addr[0] = 32'h104; push_g(0, 32'h104);
      dn.rvalid = 1'b1; dn.rdata = 32'hA0; push_r(0, 32'hA0); cyc();
      up.addr[0] = 32'h108; push_g(0, 32'h108);
      dn.rdata = 32'hA1; push_r(0, 32'hA1); cyc();
      up.req = '0; dn.rdata = 32'hA2; push_r(0, 32'hA2); cyc();
      dn.rvalid = 1'b0;
      check("t1_outstanding", 64'(outstanding), 64'd0);

      // round robin from prio 0 after reset
      reset = 1'b1; cyc(); reset = 1'b0;
      up.addr[0] = 32'h200; up.addr[1] = 32'h300;
      for (int k = 0; k <= 8; k++) begin
         up.req = (k < 8) ? 2'b11 : 2'b00;
         if (k < 8) push_g(k % 2, (k % 2) ? 32'h300 : 32'h200);
         if (k >= 1) begin
            dn.rvalid = 1'b1; dn.rdata = 32'h50 + k; push_r((k - 1) % 2, 32'h50 + k);
         end
         cyc();
         if (k == 3) check("t2_outstanding", 64'(outstanding), 64'd1);
      end
      dn.rvalid = 1'b0;
      check("t2_drained", 64'(outstanding), 64'd0);

      // lock: master 1 stalled 3 cycles, master 0 joins and must wait
      dn.gnt = 1'b0; up.req = 2'b10; up.addr[1] = 32'h400; up.addr[0] = 32'h500;
      @(negedge clk);
      check("t3_sreq", 64'(dn.req), 64'd1);
      check("t3_addr0", 64'(dn.addr[0]), 64'h400);
      cyc();
      up.req = 2'b11;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t3_addr_locked", 64'(dn.addr[0]), 64'h400);
         check("t3_no_gnt", 64'(up.gnt), 64'd0);
         cyc();
      end
      dn.gnt = 1'b1; push_g(1, 32'h400); cyc();
      up.req = 2'b01; push_g(0, 32'h500); cyc();
      up.req = '0; dn.rvalid = 1'b1; dn.rdata = 32'hB1; push_r(1, 32'hB1); cyc();
      dn.rdata = 32'hB0; push_r(0, 32'hB0); cyc();
      dn.rvalid = 1'b0;
      check("t3_outstanding", 64'(outstanding), 64'd0);

      // full FIFO gates s_req; one pop frees a slot for the next cycle
      up.req = 2'b01; up.addr[0] = 32'h600;
      for (int k = 0; k < 4; k++) begin push_g(0, 32'h600); cyc(); end
      check("t4_full", 64'(outstanding), 64'd4);
      @(negedge clk);
      check("t4_sreq_full", 64'(dn.req), 64'd0);
      cyc();
      dn.rvalid = 1'b1; dn.rdata = 32'hC0; push_r(0, 32'hC0);
      @(negedge clk);
      check("t4_sreq_popcyc", 64'(dn.req), 64'd0);
      check("t4_gnt_popcyc", 64'(up.gnt), 64'd0);
      cyc();
      check("t4_after_pop", 64'(outstanding), 64'd3);
      dn.rvalid = 1'b0; push_g(0, 32'h600);
      @(negedge clk);
      check("t4_sreq_freed", 64'(dn.req), 64'd1);
      cyc();
      check("t4_refull", 64'(outstanding), 64'd4);
      up.req = '0; dn.rvalid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         dn.rdata = 32'hC0 + k; push_r(0, 32'hC0 + k); cyc();
      end
      dn.rvalid = 1'b0;
      check("t4_drained", 64'(outstanding), 64'd0);

      // interleaved routing M0, M1, M0 with a push+pop cycle
      up.req = 2'b01; up.addr[0] = 32'h700; push_g(0, 32'h700); cyc();
      up.req = 2'b10; up.addr[1] = 32'h710; push_g(1, 32'h710); cyc();
      up.req = '0; cyc();
      check("t5_two", 64'(outstanding), 64'd2);
      up.req = 2'b01; up.addr[0] = 32'h720; push_g(0, 32'h720);
      dn.rvalid = 1'b1; dn.rdata = 32'hAAAA0001; push_r(0, 32'hAAAA0001); cyc();
      check("t5_pushpop", 64'(outstanding), 64'd2);
      up.req = '0; dn.rdata = 32'hBBBB0002; push_r(1, 32'hBBBB0002); cyc();
      check("t5_one", 64'(outstanding), 64'd1);
      dn.rdata = 32'hCCCC0003; push_r(0, 32'hCCCC0003); cyc();
      dn.rvalid = 1'b0;
      check("t5_zero", 64'(outstanding), 64'd0);

      // stray response with empty FIFO
      dn.rvalid = 1'b1; dn.rdata = 32'hDEAD;
      @(negedge clk);
      check("t6_no_rvalid", 64'(up.rvalid), 64'd0);
      cyc();
      dn.rvalid = 1'b0;
      check("t6_proto_err", 64'(proto_err), 64'd1);
      cyc();
      check("t6_sticky", 64'(proto_err), 64'd1);

      // two outstanding, leaving prio at 1, then reset
      up.req = 2'b10; up.addr[1] = 32'h810; push_g(1, 32'h810); cyc();
      up.req = 2'b01; up.addr[0] = 32'h800; push_g(0, 32'h800); cyc();
      check("t6_two", 64'(outstanding), 64'd2);
      reset = 1'b1; up.req = 2'b11; dn.rvalid = 1'b1;
      @(negedge clk);
      check("t6_rst_sreq", 64'(dn.req), 64'd0);
      check("t6_rst_gnt", 64'(up.gnt), 64'd0);
      check("t6_rst_rvalid", 64'(up.rvalid), 64'd0);
      cyc();
      reset = 1'b0; up.req = '0; dn.rvalid = 1'b0;
      check("t6_post_outstanding", 64'(outstanding), 64'd0);
      check("t6_post_proto_err", 64'(proto_err), 64'd0);
      up.req = 2'b11; push_g(0, 32'h800); cyc();
      up.req = '0; dn.rvalid = 1'b1; dn.rdata = 32'hE0; push_r(0, 32'hE0); cyc();
      check("t6_post_drain", 64'(outstanding), 64'd0);
      check("t6_post_noerr", 64'(proto_err), 64'd0);
      cyc();
      dn.rvalid = 1'b0;
      check("t6_late_rsp", 64'(proto_err), 64'd1);

      cyc(); cyc();
      check("gnt_queue_empty", 64'(gq.size()), 64'd0);
      check("rsp_queue_empty", 64'(rq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/obi_memory_rr_arbiter.md
Name: obi_memory_rr_arbiter

Overview:
- Shares one downstream OBI memory slave port between NUM_MSTR upstream OBI masters, for example instruction fetch, data and debug ports in front of a single memory model.
- Address phase: round-robin arbitration with OBI-compliant request locking.
- Response phase: in-order routing through an outstanding-transaction ID FIFO.
- Sits between core-side OBI masters and the OBI memory agent/slave in the testbench or uncore.

Parameters:
- NUM_MSTR, 2, number of upstream masters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; be width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, depth of the response-routing FIFO (power of two, >=2).

Ports:
- clk  in  1  bus clock; all timing on its rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_MSTR  per-master address request.
- m_gnt  out  NUM_MSTR  per-master grant.
- m_addr  in  NUM_MSTR*ADDR_WIDTH  per-master address, master i at slice i.
- m_we  in  NUM_MSTR  per-master write enable.
- m_be  in  NUM_MSTR*DATA_WIDTH/8  per-master byte enables.
- m_wdata  in  NUM_MSTR*DATA_WIDTH  per-master write data.
- m_rvalid  out  NUM_MSTR  per-master response valid.
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters.
- m_err  out  1  error, broadcast and qualified by m_rvalid.
- s_req  out  1  downstream request.
- s_gnt  in  1  downstream grant.
- s_addr  out  ADDR_WIDTH  downstream address.
- s_we  out  1  downstream write enable.
- s_be  out  DATA_WIDTH/8  downstream byte enables.
- s_wdata  out  DATA_WIDTH  downstream write data.
- s_rvalid  in  1  downstream response valid; rready is tied high downstream.
- s_rdata  in  DATA_WIDTH  downstream read data.
- s_err  in  1  downstream error.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- proto_err  out  1  sticky flag: s_rvalid arrived with the FIFO empty.

Behaviour:
- Reset (reset=1 at posedge):
  - prio pointer = 0; lock = 0; FIFO empty; outstanding = 0; proto_err = 0.
  - Combinationally during reset: s_req = 0, m_gnt = 0, m_rvalid = 0.
  - Reset mid-transaction drops all pending routing state; responses arriving after reset set proto_err.
- Selection:
  - If lock = 1, sel = locked index.
  - Otherwise sel = first requesting master at or after prio, searching upward with wrap-around modulo NUM_MSTR.
  - No requesters: sel = prio, s_req = 0.
- Downstream request:
  - s_req = m_req[sel] & ~full.
  - s_addr/s_we/s_be/s_wdata = slices of master sel; combinational, zero-cycle latency.
- Grant: m_gnt[sel] = s_gnt & s_req. All other m_gnt bits are 0; at most one m_gnt bit is high per cycle.
- Lock:
  - Set lock = 1 and capture sel when s_req=1 and s_gnt=0.
  - Clear lock on accept (s_req & s_gnt).
  - This holds the selection stable while an OBI master waits for its grant; a non-granted master must not be pre-empted.
- Accept (s_req & s_gnt):
  - Push sel into the FIFO.
  - prio = (sel+1) mod NUM_MSTR.
- Full: when FIFO occupancy = MAX_OUTSTANDING, s_req is forced to 0, so no accept and no m_gnt. A lock already set stays set and the same master is served once space frees.
- Response:
  - m_rvalid[head] = s_rvalid when the FIFO is non-empty; pop on s_rvalid.
  - m_rdata = s_rdata; m_err = s_err; zero-cycle latency.
- Simultaneous accept and response in the same cycle: push and pop both occur and occupancy is unchanged. When full, s_req is already gated, so only the pop occurs.
- Empty FIFO with s_rvalid=1: all m_rvalid = 0; proto_err is set and stays set until reset.
- Throughput: one accept per cycle with zero-wait-state grants, alternating between masters when several are requesting.
- No combinational path from s_gnt to s_req.

Test Plan:
1. Single master:
   - Stimulus: master 0 issues 3 reads (addr 0x100/0x104/0x108) with s_gnt=1 and responses 1 cycle later.
   - Required: s_addr matches, m_gnt[0] pulses 3 times, m_rvalid[0] 3 times with correct rdata, outstanding returns to 0.
2. Round-robin:
   - Stimulus: masters 0 and 1 request continuously with s_gnt=1.
   - Required: grants alternate 0,1,0,1; no master is starved over 8 accepts.
3. Lock:
   - Stimulus: master 1 requests; s_gnt is held 0 for 3 cycles; master 0 raises req on cycle 1.
   - Required: s_addr stays master 1's address for all stall cycles; master 1 is granted first, master 0 next.
4. Full FIFO (MAX_OUTSTANDING=4):
   - Stimulus: 4 accepts with no responses.
   - Required: outstanding=4; s_req=0 although m_req=1; after one s_rvalid, the next grant occurs the following cycle.
5. Interleaved routing:
   - Stimulus: accepts in order M0,M1,M0 with delayed responses carrying s_rdata A,B,C, one response on the same cycle as a new accept.
   - Required: m_rvalid[0] with A, m_rvalid[1] with B, m_rvalid[0] with C; outstanding is correct throughout.
6. Protocol error and reset:
   - Stimulus: s_rvalid=1 with the FIFO empty, then reset asserted mid-burst with 2 transactions outstanding.
   - Required: proto_err=1, no m_rvalid; after reset, outstanding=0, proto_err=0, prio=0.
